// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its frame debouncer.
// Frame classification lives here so the top and any checker agree on it.
package keypad_pkg;

    localparam int          KEY_CODE_W         = 4;
    localparam int          NUM_KEYS           = 16;
    localparam int          NUM_COLS           = 4;
    localparam logic [18:0] T_SCAN_DEFAULT     = 19'd49_999;
    localparam int          DEB_FRAMES_DEFAULT = 5;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_t;

    typedef struct packed {
        frame_class_t          cls;
        logic [KEY_CODE_W-1:0] idx;
    } frame_info_t;

    // Column drive pattern: the active column is the only low bit.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // idx is the lowest set bit; it is only meaningful when cls is SINGLE.
    function automatic frame_info_t classify_frame(input logic [NUM_KEYS-1:0] snap);
        frame_info_t info;
        logic [4:0]  n;
        info.cls = ZERO;
        info.idx = '0;
        n        = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snap[i]) begin
                n        = n + 5'd1;
                info.idx = KEY_CODE_W'(i);
            end
        end
        if (n == 5'd1)
            info.cls = SINGLE;
        else if (n != 5'd0)
            info.cls = MULTI;
        return info;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: accepts a press or release only after DEB_FRAMES
// consecutive agreeing frames, and owns the key code / strobe / down outputs.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_FRAMES = DEB_FRAMES_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_done,
    input  frame_class_t          frame_cls,
    input  logic [KEY_CODE_W-1:0] frame_idx,
    output logic [KEY_CODE_W-1:0] Key_Code,
    output logic                  Key_Valid,
    output logic                  Key_Down,
    output deb_state_t            dbg_state
);

    localparam logic [3:0] DEB_CNT = 4'(DEB_FRAMES);

    deb_state_t            state, state_n;
    logic [3:0]            cnt, cnt_n, cnt_inc;
    logic [KEY_CODE_W-1:0] cand, cand_n;
    logic [KEY_CODE_W-1:0] code_q, code_n;
    logic                  valid_q, valid_n;
    logic                  down_q, down_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RELEASED;
            cnt     <= '0;
            cand    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cand    <= cand_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            down_q  <= down_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = code_q;
        valid_n = 1'b0;
        down_n  = down_q;
        cnt_inc = cnt + 4'd1;
        if (frame_done) begin
            case (state)
                RELEASED: begin
                    if (frame_cls == SINGLE) begin
                        state_n = PRESS_CHK;
                        cand_n  = frame_idx;
                        cnt_n   = 4'd1;
                    end
                end
                PRESS_CHK: begin
                    if (frame_cls == SINGLE && frame_idx == cand) begin
                        if (cnt_inc == DEB_CNT) begin
                            state_n = PRESSED;
                            cnt_n   = '0;
                            code_n  = cand;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // A different key does not become the new candidate here.
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_cls == ZERO) begin
                        state_n = RELEASE_CHK;
                        cnt_n   = 4'd1;
                    end
                end
                RELEASE_CHK: begin
                    if (frame_cls == ZERO) begin
                        if (cnt_inc == DEB_CNT) begin
                            state_n = RELEASED;
                            cnt_n   = '0;
                            down_n  = 1'b0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Key_Valid is a one-cycle strobe with no ready: downstream must capture
    // Key_Code in the cycle Key_Valid is high; Key_Code is stable until the next strobe.
    assign Key_Code  = code_q;
    assign Key_Valid = valid_q;
    assign Key_Down  = down_q;
    assign dbg_state = state;

endmodule

// File: rtl/keypad_scan_module.sv
// 4x4 keypad column scanner: strobes columns, synchronises rows, builds one
// 16-key snapshot per frame and hands its classification to the debouncer.
module keypad_scan_module
    import keypad_pkg::*;
#(
    parameter logic [18:0] T_SCAN     = T_SCAN_DEFAULT,
    parameter int          DEB_FRAMES = DEB_FRAMES_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            Key_Row_In,
    output logic [3:0]            Key_Col_Sig,
    output logic [KEY_CODE_W-1:0] Key_Code,
    output logic                  Key_Valid,
    output logic                  Key_Down,
    output deb_state_t            dbg_state
);

    logic [3:0]          row_meta, row_sync;
    logic [18:0]         slot_cnt;
    logic                slot_end;
    logic [1:0]          col_idx, col_idx_n;
    logic [3:0]          col_sig;
    logic [NUM_KEYS-1:0] snapshot, snapshot_n;
    logic                last_sample;
    logic                frame_done;
    frame_info_t         frame_info;

    assign slot_end  = (slot_cnt == T_SCAN);
    assign col_idx_n = col_idx + 2'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= Key_Row_In;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt <= '0;
            col_idx  <= '0;
            col_sig  <= 4'b1110;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col_idx  <= col_idx_n;
            col_sig  <= col_drive(col_idx_n);
        end else begin
            slot_cnt <= slot_cnt + 19'd1;
        end
    end

    // Column 0 starts a fresh frame, so nothing from the previous frame leaks in.
    always_comb begin
        snapshot_n = snapshot;
        if (slot_end) begin
            if (col_idx == 2'd0)
                snapshot_n = '0;
            for (int r = 0; r < 4; r++)
                snapshot_n[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    // frame_done trails the column-3 sample by a full cycle so the snapshot
    // and its classification are settled before the debouncer looks at them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            snapshot    <= '0;
            last_sample <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            snapshot    <= snapshot_n;
            last_sample <= slot_end && (col_idx == 2'd3);
            frame_done  <= last_sample;
        end
    end

    assign frame_info  = classify_frame(snapshot);
    assign Key_Col_Sig = col_sig;

    keypad_frame_debounce #(
        .DEB_FRAMES (DEB_FRAMES)
    ) u_debounce (
        .CLK        (CLK),
        .RST        (RST),
        .frame_done (frame_done),
        .frame_cls  (frame_info.cls),
        .frame_idx  (frame_info.idx),
        .Key_Code   (Key_Code),
        .Key_Valid  (Key_Valid),
        .Key_Down   (Key_Down),
        .dbg_state  (dbg_state)
    );

endmodule

// File: tb/tb_keypad_scan_module.sv
// Bench for keypad_scan_module with a fast scan (T_SCAN=3, DEB_FRAMES=3):
// frame-level key model, run-length reference, scoreboard queues and monitor.
module tb_keypad_scan_module;
  import keypad_pkg::*;

  localparam int DEB = 3;
  localparam int FRAME_CLKS = 16;

  logic        CLK;
  logic        RST;
  logic [3:0]  row_in;
  logic [3:0]  Key_Col_Sig;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic        Key_Down;
  deb_state_t  dbg_state;

  logic [15:0] held;
  int          cyc;
  logic        mon_en;
  logic        prev_down;
  int          tests;
  int          fails;

  // expected press: {cycle[15:0], code[3:0]}; expected release: cycle[15:0]
  logic [19:0] exp_press_q[$];
  logic [15:0] exp_rel_q[$];

  // reference model state (frame-level run lengths)
  int          m_pressed;
  int          m_code;
  int          m_run_key;
  int          m_run_len;
  int          m_zero_run;
  int          m_fno;

  keypad_scan_module #(
    .T_SCAN     (19'd3),
    .DEB_FRAMES (DEB)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Key_Row_In  (row_in),
    .Key_Col_Sig (Key_Col_Sig),
    .Key_Code    (Key_Code),
    .Key_Valid   (Key_Valid),
    .Key_Down    (Key_Down),
    .dbg_state   (dbg_state)
  );

  // clock / reset-relative cycle count
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // keypad: a held key (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_in = 4'hF;
    for (int k = 0; k < 16; k++)
      if (held[k] && !Key_Col_Sig[k % 4]) row_in[k / 4] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pressed  = 0;
    m_code     = 0;
    m_run_key  = 0;
    m_run_len  = 0;
    m_zero_run = 0;
    m_fno      = 0;
  endtask

  // One frame with key set m: an accepted press/release becomes visible
  // two clocks after this frame's last column sample (cycle 16*frame+2).
  task automatic model_frame(input logic [15:0] m);
    int n;
    int k;
    logic [15:0] at;
    n = $countones(m);
    m_fno++;
    at = 16'(m_fno * FRAME_CLKS + 2);
    if (m_pressed == 0) begin
      if (n == 1) begin
        k = idx_of(m);
        if (m_run_len > 0 && k != m_run_key) m_run_len = 0;
        else if (m_run_len > 0) m_run_len++;
        else begin
          m_run_key = k;
          m_run_len = 1;
        end
        if (m_run_len == DEB) begin
          m_pressed  = 1;
          m_code     = k;
          m_run_len  = 0;
          m_zero_run = 0;
          exp_press_q.push_back({at, 4'(k)});
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (n == 0) m_zero_run++;
      else        m_zero_run = 0;
      if (m_zero_run == DEB) begin
        m_pressed  = 0;
        m_zero_run = 0;
        exp_rel_q.push_back(at);
      end
    end
  endtask

  // driver: hold key set m for n frames, aligned to frame start
  task automatic play(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      held = m;
      repeat (3) @(posedge CLK);
      #1;
      check("key_down", 32'(Key_Down), 32'(m_pressed));
      check("key_code", 32'(Key_Code), 32'(m_code));
      model_frame(m);
      repeat (FRAME_CLKS - 3) @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [15:0] bit_of(input int k);
    logic [15:0] one;
    one = 16'h0001;
    return one << k;
  endfunction

  // monitor: column rotation, press strobes and release edges
  always @(negedge CLK) begin
    logic [3:0]  exp_col;
    logic [19:0] e;
    logic [15:0] r;
    if (mon_en && !RST) begin
      exp_col = 4'hF ^ (4'h1 << cyc[3:2]);
      check("col_sig", 32'(Key_Col_Sig), 32'(exp_col));
      if (Key_Valid) begin
        if (exp_press_q.size() == 0) begin
          check("unexpected_valid", 32'(Key_Code), 32'hFFFF);
        end else begin
          e = exp_press_q.pop_front();
          check("valid_cycle", 32'(cyc[15:0]), 32'(e[19:4]));
          check("valid_code", 32'(Key_Code), 32'(e[3:0]));
          check("down_at_valid", 32'(Key_Down), 32'd1);
        end
      end else if (exp_press_q.size() > 0 && exp_press_q[0][19:4] < cyc[15:0]) begin
        e = exp_press_q.pop_front();
        check("missed_valid", 32'(cyc[15:0]), 32'(e[19:4]));
      end
      if (prev_down && !Key_Down) begin
        if (exp_rel_q.size() == 0) begin
          check("unexpected_release", 32'(cyc[15:0]), 32'hFFFF);
        end else begin
          r = exp_rel_q.pop_front();
          check("release_cycle", 32'(cyc[15:0]), 32'(r));
        end
      end else if (exp_rel_q.size() > 0 && exp_rel_q[0] < cyc[15:0]) begin
        r = exp_rel_q.pop_front();
        check("missed_release", 32'(cyc[15:0]), 32'(r));
      end
      prev_down <= Key_Down;
    end else begin
      prev_down <= 1'b0;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_col"},   32'(Key_Col_Sig), 32'hE);
    check({tag, "_code"},  32'(Key_Code),    32'h0);
    check({tag, "_valid"}, 32'(Key_Valid),   32'h0);
    check({tag, "_down"},  32'(Key_Down),    32'h0);
    check({tag, "_state"}, 32'(dbg_state),   32'(RELEASED));
  endtask

  initial begin
    int kind, len, a, b;
    logic [15:0] m;
    tests  = 0;
    fails  = 0;
    mon_en = 1'b0;
    held   = '0;
    model_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values("reset");
    RST    = 1'b0;
    mon_en = 1'b1;

    // idle, then key 6 (row1/col2) held stably
    play(16'h0000, 1);
    play(bit_of(6), 5);
    play(16'h0000, 4);

    // bounce on key 6, then a stable hold
    play(bit_of(6), 2);
    play(16'h0000, 1);
    play(bit_of(6), 2);
    play(16'h0000, 1);
    play(bit_of(6), 3);
    play(16'h0000, 4);

    // keys 0 and 5 together: never accepted
    play(bit_of(0) | bit_of(5), 3);
    play(16'h0000, 1);

    // key 9 accepted, key 3 added: code held, no strobe
    play(bit_of(9), 3);
    play(bit_of(9) | bit_of(3), 2);
    play(bit_of(9), 1);
    check("code_held_9", 32'(Key_Code), 32'd9);

    // short release then re-press, then a full release
    play(16'h0000, 2);
    play(bit_of(9), 2);
    check("down_kept", 32'(Key_Down), 32'd1);
    play(16'h0000, 4);

    // reset in PRESS_CHK with count 2
    play(bit_of(6), 2);
    check("pre_reset_state", 32'(dbg_state), 32'(PRESS_CHK));
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_reset_values("midreset");
    RST = 1'b0;
    model_reset();
    play(bit_of(6), 4);
    play(16'h0000, 4);

    // randomized frame runs
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 4);
      a    = $urandom_range(0, 15);
      b    = (a + 1 + $urandom_range(0, 14)) % 16;
      case (kind)
        0:       m = 16'h0000;
        3:       m = bit_of(a) | bit_of(b);
        default: m = bit_of(a);
      endcase
      play(m, len);
    end
    play(16'h0000, 4);

    repeat (4) @(posedge CLK);
    #1;
    check("press_q_empty", 32'(exp_press_q.size()), 32'd0);
    check("rel_q_empty", 32'(exp_rel_q.size()), 32'd0);
    check("final_down", 32'(Key_Down), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
